// File: rtl/line_scroller_pkg.sv
// Shared definitions for the scrolling line generator: FSM encoding and
// default LFSR tap masks / seeds per register width.
package line_scroller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Maximal-length Fibonacci tap masks for the supported widths.
  function automatic logic [31:0] default_taps(input int width);
    case (width)
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_B400;
      32:      return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] default_seed(input int width);
    case (width)
      8:       return 32'h0000_00E1;
      16:      return 32'h0000_ACE1;
      32:      return 32'hACE1_ACE1;
      default: return 32'h0000_0001;
    endcase
  endfunction

endpackage

// File: rtl/line_scroller_lfsr_core.sv
// Fibonacci LFSR: shifts left, feedback (XOR of tapped bits) enters at bit 0.
// An all-zero state reloads SEED on the next step instead of locking up.
module lfsr_core #(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              step_i,
  output logic [LFSR_W-1:0] state_o
);

  logic feedback;

  assign feedback = ^(state_o & TAPS);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_o <= SEED;
    end else if (step_i) begin
      if (state_o == '0) state_o <= SEED;
      else               state_o <= {state_o[LFSR_W-2:0], feedback};
    end
  end

endmodule

// File: rtl/line_scroller.sv
// WIDTH-bit scrolling line; each command shifts in N pseudo-random bits at
// the MSB, one per clock, with a cap on consecutive inserted zeros.
module line_scroller
  import line_scroller_pkg::*;
#(
  parameter int                WIDTH        = 640,
  parameter int                LFSR_W       = 16,
  parameter logic [LFSR_W-1:0] TAPS         = LFSR_W'(default_taps(LFSR_W)),
  parameter logic [LFSR_W-1:0] SEED         = LFSR_W'(default_seed(LFSR_W)),
  parameter int                CNT_W        = 8,
  parameter int                DENSITY_W    = 4,
  parameter int                MAX_ZERO_RUN = 31
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 clear_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [CNT_W-1:0]     cmd_count_i,
  input  logic [DENSITY_W-1:0] density_i,
  output logic [WIDTH-1:0]     line_o,
  output logic                 bit_valid_o,
  output logic                 bit_o,
  output logic                 done_o
);

  localparam int ZR_W = $clog2(MAX_ZERO_RUN + 1);

  state_e            state;
  logic [CNT_W-1:0]  remaining;
  logic [ZR_W-1:0]   zero_run;
  logic [LFSR_W-1:0] lfsr_state;
  logic              step;
  logic              rand_bit;
  logic              new_bit;
  logic              unused_lfsr_bits;

  // The LFSR only advances on real shift cycles; a clear cancels the step.
  assign step = (state == ST_SHIFT) && !clear_i;

  lfsr_core #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS),
    .SEED   (SEED)
  ) u_lfsr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .step_i  (step),
    .state_o (lfsr_state)
  );

  assign unused_lfsr_bits = ^lfsr_state[LFSR_W-1:DENSITY_W];

  // NOTE: every output of a combinational block gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    rand_bit = 1'b0;
    new_bit  = 1'b0;
    if (density_i == '1) rand_bit = 1'b1;
    else                 rand_bit = (lfsr_state[DENSITY_W-1:0] < density_i);
    if (zero_run == ZR_W'(MAX_ZERO_RUN)) new_bit = 1'b1;
    else                                 new_bit = rand_bit;
  end

  // done_o is registered from the DONE state, so it appears the cycle after
  // the FSM sits in DONE: N+1 cycles after the handshake edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= ST_IDLE;
      line_o      <= '1;
      cmd_ready_o <= 1'b1;
      done_o      <= 1'b0;
      bit_valid_o <= 1'b0;
      bit_o       <= 1'b0;
      zero_run    <= '0;
      remaining   <= '0;
    end else if (clear_i) begin
      state       <= ST_IDLE;
      line_o      <= '1;
      cmd_ready_o <= 1'b1;
      done_o      <= 1'b0;
      bit_valid_o <= 1'b0;
      bit_o       <= 1'b0;
      zero_run    <= '0;
      remaining   <= '0;
    end else begin
      done_o      <= 1'b0;
      bit_valid_o <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          done_o <= (state == ST_DONE);
          if (cmd_valid_i && cmd_count_i != '0) begin
            remaining   <= cmd_count_i;
            state       <= ST_SHIFT;
            cmd_ready_o <= 1'b0;
          end else if (cmd_valid_i) begin
            // A zero-length command completes immediately via DONE.
            state       <= ST_DONE;
            cmd_ready_o <= 1'b1;
          end else begin
            state       <= ST_IDLE;
            cmd_ready_o <= 1'b1;
          end
        end
        ST_SHIFT: begin
          line_o      <= {new_bit, line_o[WIDTH-1:1]};
          bit_valid_o <= 1'b1;
          bit_o       <= new_bit;
          zero_run    <= new_bit ? '0 : zero_run + ZR_W'(1);
          remaining   <= remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            state       <= ST_DONE;
            cmd_ready_o <= 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          cmd_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_scroller.sv
// Directed bench for line_scroller with an independent LFSR / run-guard model.
module tb_line_scroller;
  import line_scroller_pkg::*;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         clear_i;
  logic         cmd_valid_i;
  logic         cmd_ready_o;
  logic [7:0]   cmd_count_i;
  logic [3:0]   density_i;
  logic [639:0] line_o;
  logic         bit_valid_o;
  logic         bit_o;
  logic         done_o;

  int n_checks = 0;
  int n_pass   = 0;
  int bits_seen;
  int ones;
  logic [15:0] m_lfsr;
  int          m_zr;

  line_scroller dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .clear_i     (clear_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_count_i (cmd_count_i),
    .density_i   (density_i),
    .line_o      (line_o),
    .bit_valid_o (bit_valid_o),
    .bit_o       (bit_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    if (s == 16'h0000) return 16'hACE1;
    return {s[14:0], ^(s & 16'hB400)};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [7:0] n);
    check("ready_before_cmd", 64'(cmd_ready_o), 64'd1);
    cmd_valid_i = 1'b1;
    cmd_count_i = n;
    tick();
    cmd_valid_i = 1'b0;
    cmd_count_i = 8'd0;
  endtask

  // Advance n shift cycles, checking each inserted bit against the model.
  task automatic shift_expect(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      logic r, b;
      tick();
      r = (density_i == 4'hF) ? 1'b1 : (m_lfsr[3:0] < density_i);
      b = (m_zr == 31) ? 1'b1 : r;
      check({tag, "_valid"}, 64'(bit_valid_o), 64'd1);
      check({tag, "_bit"}, 64'(bit_o), 64'(b));
      m_zr   = b ? 0 : m_zr + 1;
      m_lfsr = lfsr_next(m_lfsr);
      bits_seen += int'(bit_valid_o);
      ones      += int'(bit_o);
    end
  endtask

  task automatic finish_cmd(input string tag);
    check({tag, "_done_early"}, 64'(done_o), 64'd0);
    check({tag, "_ready_in_done"}, 64'(cmd_ready_o), 64'd1);
    tick();
    check({tag, "_done"}, 64'(done_o), 64'd1);
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    m_zr = 0;
  endtask

  initial begin
    logic quiet;
    reset_i     = 1'b1;
    clear_i     = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_count_i = 8'd0;
    density_i   = 4'h0;
    m_lfsr      = 16'hACE1;
    m_zr        = 0;
    bits_seen   = 0;
    ones        = 0;

    // Reset held
    tick();
    tick();
    check("rst_line", 64'(line_o == '1), 64'd1);
    check("rst_ready", 64'(cmd_ready_o), 64'd1);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_bit_valid", 64'(bit_valid_o), 64'd0);
    check("rst_lfsr", 64'(dut.u_lfsr.state_o), 64'hACE1);
    reset_i = 1'b0;
    tick();
    check("idle_done", 64'(done_o), 64'd0);

    // count=5, full density: all ones, done 6 cycles after handshake
    density_i = 4'hF;
    issue(8'd5);
    check("d15_ready_busy", 64'(cmd_ready_o), 64'd0);
    shift_expect(5, "d15");
    check("d15_line", 64'(line_o == '1), 64'd1);
    finish_cmd("d15");
    tick();
    check("d15_done_gone", 64'(done_o), 64'd0);

    // count=64, zero density: guard forces bits 32 and 64
    pulse_clear();
    density_i = 4'h0;
    issue(8'd64);
    shift_expect(64, "d0");
    check("d0_line_top", line_o[639:576], 64'h8000_0000_8000_0000);
    check("d0_line_rest", 64'(line_o[575:0] == '1), 64'd1);
    finish_cmd("d0");

    // count=10 aborted by clear on the 4th shift cycle; valid ignored
    density_i = 4'h8;
    issue(8'd10);
    shift_expect(3, "clr");
    clear_i     = 1'b1;
    cmd_valid_i = 1'b1;
    cmd_count_i = 8'd7;
    tick();
    clear_i     = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_count_i = 8'd0;
    m_zr        = 0;
    check("clr_line", 64'(line_o == '1), 64'd1);
    check("clr_ready", 64'(cmd_ready_o), 64'd1);
    check("clr_bit_valid", 64'(bit_valid_o), 64'd0);
    check("clr_done", 64'(done_o), 64'd0);
    check("clr_state", 64'(dut.state), 64'(ST_IDLE));
    check("clr_lfsr_3_steps", 64'(dut.u_lfsr.state_o), 64'(m_lfsr));
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done_o || bit_valid_o) quiet = 1'b0;
    end
    check("clr_quiet_after", 64'(quiet), 64'd1);

    // count=0: no shift, done one cycle after handshake
    density_i = 4'hF;
    issue(8'd0);
    check("zero_bit_valid", 64'(bit_valid_o), 64'd0);
    check("zero_done_early", 64'(done_o), 64'd0);
    tick();
    check("zero_done", 64'(done_o), 64'd1);
    check("zero_no_shift", 64'(bit_valid_o), 64'd0);
    tick();

    // Back-to-back: count=2 accepted while in DONE of count=3
    bits_seen = 0;
    issue(8'd3);
    shift_expect(3, "b2b_a");
    check("b2b_ready_in_done", 64'(cmd_ready_o), 64'd1);
    cmd_valid_i = 1'b1;
    cmd_count_i = 8'd2;
    tick();
    cmd_valid_i = 1'b0;
    cmd_count_i = 8'd0;
    check("b2b_first_done", 64'(done_o), 64'd1);
    check("b2b_busy", 64'(cmd_ready_o), 64'd0);
    shift_expect(2, "b2b_b");
    check("b2b_total_bits", 64'(bits_seen), 64'd5);
    finish_cmd("b2b");

    // 4096 shifts at density 8 against the reference model
    pulse_clear();
    density_i = 4'h8;
    ones = 0;
    for (int c = 0; c < 32; c++) begin
      issue(8'd128);
      shift_expect(128, "rnd");
      finish_cmd("rnd");
    end
    check("rnd_ones_fraction", 64'(ones >= 1843 && ones <= 2253), 64'd1);
    check("rnd_lfsr", 64'(dut.u_lfsr.state_o), 64'(m_lfsr));

    // Reset in the middle of a shift
    issue(8'd20);
    shift_expect(2, "mid_rst");
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("mrst_line", 64'(line_o == '1), 64'd1);
    check("mrst_ready", 64'(cmd_ready_o), 64'd1);
    check("mrst_bit_valid", 64'(bit_valid_o), 64'd0);
    check("mrst_lfsr", 64'(dut.u_lfsr.state_o), 64'hACE1);
    tick();
    check("mrst_no_done", 64'(done_o), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
